regfile_2w2r: RTL and testbench

Parametrised multi-port register file: two write ports, two asynchronous read ports, optional hardwired-zero register 0, optional write-to-read bypass, and a sequenced bulk-clear engine. It replaces the fixed 8-entry, 8-bit, single-write-port register file in the datapath and serves as the operand store for the two-issue execution stage.

---
 rtl/regfile_2w2r_if.sv | 29 ++
 rtl/regfile_2w2r.sv | 98 +++++++++
 tb/tb_regfile_2w2r.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_2w2r_if.sv
// Bus bundle for the two-write / two-read register file: write ports 3/4,
// read ports 1/2, and the bulk-clear request/status pair.
interface regfile_2w2r_if #(
   parameter int WIDTH  = 8,
   parameter int ADDR_W = 3
);
   logic              we3;
   logic [ADDR_W-1:0] wa3;
   logic [WIDTH-1:0]  wd3;
   logic              we4;
   logic [ADDR_W-1:0] wa4;
   logic [WIDTH-1:0]  wd4;
   logic [ADDR_W-1:0] ra1;
   logic [ADDR_W-1:0] ra2;
   logic [WIDTH-1:0]  rd1;
   logic [WIDTH-1:0]  rd2;
   logic              clr;
   logic              busy;

   modport master (
      output we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, clr,
      input  rd1, rd2, busy
   );

   modport slave (
      input  we3, wa3, wd3, we4, wa4, wd4, ra1, ra2, clr,
      output rd1, rd2, busy
   );
endinterface

// File: rtl/regfile_2w2r.sv
// Parametrised register file: two write ports (port 4 wins collisions), two
// combinational read ports with optional bypass, optional zero register, bulk clear.
module regfile_2w2r #(
   parameter int WIDTH    = 8,
   parameter int ADDR_W   = 3,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   regfile_2w2r_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;

   localparam logic [0:0] S_IDLE  = 1'b0;
   localparam logic [0:0] S_CLEAR = 1'b1;

   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]  regs_q [DEPTH];
   logic [WIDTH-1:0]  regs_d [DEPTH];

   logic idle;
   logic we3_ok;
   logic we4_ok;

   assign idle   = (state_q == S_IDLE);
   assign we3_ok = idle && bus.we3 && !(ZERO_REG && bus.wa3 == '0);
   assign we4_ok = idle && bus.we4 && !(ZERO_REG && bus.wa4 == '0);

   // Clear sequencer: IDLE -> CLEAR on clr, then one register per cycle.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == S_IDLE) begin
         if (bus.clr) begin
            state_d = S_CLEAR;
            cnt_d   = '0;
         end
      end else begin
         cnt_d = cnt_q + ADDR_W'(1);
         if (cnt_q == ADDR_W'(DEPTH - 1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      end
   end

   always_comb begin
      regs_d = regs_q;
      if (state_q == S_IDLE) begin
         if (we3_ok) regs_d[bus.wa3] = bus.wd3;
         if (we4_ok) regs_d[bus.wa4] = bus.wd4;
      end else begin
         regs_d[cnt_q] = '0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // NOTE: the storage array is reset because reset must read back all zeros without a clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) regs_q[i] <= regs_d[i];
      end
   end

   // Port 4 is checked last so it has priority, matching the commit order above.
   function automatic logic [WIDTH-1:0] read_mux(
      input logic [ADDR_W-1:0] ra,
      input logic [WIDTH-1:0]  stored
   );
      logic [WIDTH-1:0] v;
      v = stored;
      if (BYPASS && idle && bus.we3 && bus.wa3 == ra) v = bus.wd3;
      if (BYPASS && idle && bus.we4 && bus.wa4 == ra) v = bus.wd4;
      if (ZERO_REG && ra == '0) v = '0;
      return v;
   endfunction

   assign bus.rd1  = read_mux(bus.ra1, regs_q[bus.ra1]);
   assign bus.rd2  = read_mux(bus.ra2, regs_q[bus.ra2]);
   assign bus.busy = (state_q == S_CLEAR);

endmodule

// File: tb/tb_regfile_2w2r.sv
// Bench for regfile_2w2r: one instance with zero-reg+bypass, one without, driven
// in lockstep; expectations are queued at stimulus time and popped when read.
`timescale 1ns/1ps
module tb_regfile_2w2r;

   logic       clk;
   logic       rst;
   logic       we3, we4, clr;
   logic [2:0] wa3, wa4, ra1, ra2;
   logic [7:0] wd3, wd4;

   regfile_2w2r_if #(.WIDTH(8), .ADDR_W(3)) ifa ();
   regfile_2w2r_if #(.WIDTH(8), .ADDR_W(3)) ifb ();

   assign ifa.we3 = we3;  assign ifb.we3 = we3;
   assign ifa.wa3 = wa3;  assign ifb.wa3 = wa3;
   assign ifa.wd3 = wd3;  assign ifb.wd3 = wd3;
   assign ifa.we4 = we4;  assign ifb.we4 = we4;
   assign ifa.wa4 = wa4;  assign ifb.wa4 = wa4;
   assign ifa.wd4 = wd4;  assign ifb.wd4 = wd4;
   assign ifa.ra1 = ra1;  assign ifb.ra1 = ra1;
   assign ifa.ra2 = ra2;  assign ifb.ra2 = ra2;
   assign ifa.clr = clr;  assign ifb.clr = clr;

   regfile_2w2r #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
      .clk (clk),
      .rst (rst),
      .bus (ifa)
   );

   regfile_2w2r #(.WIDTH(8), .ADDR_W(3), .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
      .clk (clk),
      .rst (rst),
      .bus (ifb)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      string      name;
      int         sel;
      logic [7:0] exp;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   logic [7:0] obs;
   int n_cmp = 0;
   int n_err = 0;

   function automatic logic [7:0] observe(input int sel);
      case (sel)
         0:       return ifa.rd1;
         1:       return ifa.rd2;
         2:       return ifb.rd1;
         3:       return ifb.rd2;
         4:       return {7'b0, ifa.busy};
         default: return {7'b0, ifb.busy};
      endcase
   endfunction

   task automatic push(input string name, input int sel, input logic [7:0] v);
      exp_t x;
      x.name = name;
      x.sel  = sel;
      x.exp  = v;
      sb.push_back(x);
   endtask

   task automatic exp_rd1(input string name, input logic [7:0] va, input logic [7:0] vb);
      push({name, "/rd1_a"}, 0, va);
      push({name, "/rd1_b"}, 2, vb);
   endtask

   task automatic exp_rd2(input string name, input logic [7:0] va, input logic [7:0] vb);
      push({name, "/rd2_a"}, 1, va);
      push({name, "/rd2_b"}, 3, vb);
   endtask

   task automatic exp_busy(input string name, input logic v);
      push({name, "/busy_a"}, 4, {7'b0, v});
      push({name, "/busy_b"}, 5, {7'b0, v});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      we3 = 1'b0; wa3 = '0; wd3 = '0;
      we4 = 1'b0; wa4 = '0; wd4 = '0;
      ra1 = '0;   ra2 = '0; clr = 1'b0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 8; i++) begin
         we3 = 1'b1; wa3 = 3'(i); wd3 = 8'hF0 + 8'(i);
         tick();
      end
      we3 = 1'b0;
      #2 rst = 1'b1;
      #1;
      exp_busy("reset", 1'b0);
      for (int a = 0; a < 8; a++) begin
         ra1 = 3'(a); ra2 = 3'(7 - a);
         exp_rd1($sformatf("reset_r%0d", a), 8'h00, 8'h00);
         exp_rd2($sformatf("reset_r%0d", 7 - a), 8'h00, 8'h00);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
            if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
         end
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      we3 = 1'b1; wa3 = 3'd1; wd3 = 8'h8A;
      tick();
      we3 = 1'b0;
      we4 = 1'b1; wa4 = 3'd2; wd4 = 8'hAA;
      tick();
      we4 = 1'b0;
      ra1 = 3'd1; ra2 = 3'd2;
      exp_rd1("wr_basic", 8'h8A, 8'h8A);
      exp_rd2("wr_basic", 8'hAA, 8'hAA);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
   endtask

   task automatic test_collision_zero();
      we3 = 1'b1; wa3 = 3'd5; wd3 = 8'h11;
      we4 = 1'b1; wa4 = 3'd5; wd4 = 8'h22;
      tick();
      we4 = 1'b0;
      wa3 = 3'd0; wd3 = 8'hFF;
      tick();
      we3 = 1'b0;
      ra1 = 3'd0; ra2 = 3'd5;
      exp_rd1("zero_reg", 8'h00, 8'hFF);
      exp_rd2("collision", 8'h22, 8'h22);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
   endtask

   task automatic test_bypass();
      we4 = 1'b1; wa4 = 3'd3; wd4 = 8'hCA;
      tick();
      we4 = 1'b0;
      we3 = 1'b1; wa3 = 3'd3; wd3 = 8'h8A; ra1 = 3'd3;
      exp_rd1("bypass_same", 8'h8A, 8'hCA);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
      tick();
      we3 = 1'b0;
      exp_rd1("bypass_next", 8'h8A, 8'h8A);
      #1;
      // Both ports hit the same address: port 4 data wins bypass and commit.
      we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h33;
      we4 = 1'b1; wa4 = 3'd6; wd4 = 8'h44; ra2 = 3'd6;
      exp_rd2("bypass_prio", 8'h44, 8'h00);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
      tick();
      we3 = 1'b0; we4 = 1'b0;
      exp_rd2("prio_commit", 8'h44, 8'h44);
      we4 = 1'b1; wa4 = 3'd0; wd4 = 8'h77; ra1 = 3'd0;
      exp_rd1("bypass_zero", 8'h00, 8'hFF);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
      tick();
      we4 = 1'b0;
      exp_rd1("zero_commit", 8'h00, 8'h77);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
   endtask

   task automatic test_bulk_clear();
      logic [7:0] old_a [8];
      logic [7:0] old_b [8];
      for (int i = 1; i < 8; i++) begin
         we3 = 1'b1; wa3 = 3'(i); wd3 = 8'(i);
         old_a[i] = 8'(i); old_b[i] = 8'(i);
         tick();
      end
      we3 = 1'b0;
      old_a[0] = 8'h00; old_b[0] = 8'h77;
      exp_busy("clr_pre", 1'b0);
      clr = 1'b1;
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
      tick();
      clr = 1'b0;
      we3 = 1'b1; wa3 = 3'd4; wd3 = 8'h55;
      for (int k = 0; k < 8; k++) begin
         ra1 = 3'(k);
         exp_busy($sformatf("clr_busy%0d", k), 1'b1);
         exp_rd1($sformatf("clr_old%0d", k), old_a[k], old_b[k]);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
            if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
         end
         tick();
         exp_rd1($sformatf("clr_wiped%0d", k), 8'h00, 8'h00);
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
            if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
         end
      end
      ra1 = 3'd4;
      exp_busy("clr_done", 1'b0);
      exp_rd1("clr_write_byp", 8'h55, 8'h00);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
      tick();
      we3 = 1'b0;
      exp_rd1("clr_write_commit", 8'h55, 8'h55);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
   endtask

   task automatic test_reset_mid_clear();
      int cycles;
      for (int i = 1; i < 8; i++) begin
         we3 = 1'b1; wa3 = 3'(i); wd3 = 8'h10 + 8'(i);
         tick();
      end
      we3 = 1'b0;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1;
      exp_busy("rstmid_busy", 1'b0);
      #1;
      for (int k = 3; k < 8; k++) begin
         ra1 = 3'(k);
         exp_rd1($sformatf("rstmid_r%0d", k), 8'h00, 8'h00);
         #1;
         while (sb.size() > 0) begin
            e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
            if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
         end
      end
      rst = 1'b0;
      we3 = 1'b1; wa3 = 3'd6; wd3 = 8'h66;
      tick();
      we3 = 1'b0;
      ra1 = 3'd6;
      exp_rd1("rstmid_write", 8'h66, 8'h66);
      #1;
      clr = 1'b1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
      tick();
      clr = 1'b0;
      exp_busy("reclr_start", 1'b1);
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
      cycles = 0;
      while (ifa.busy && cycles < 20) begin
         tick();
         cycles++;
      end
      n_cmp++;
      if (cycles !== 8) begin
         n_err++;
         $display("FAIL reclr_len: got %0d edges want 8", cycles);
      end
      exp_busy("reclr_end", 1'b0);
      exp_rd1("reclr_wiped", 8'h00, 8'h00);
      #1;
      while (sb.size() > 0) begin
         e = sb.pop_front(); obs = observe(e.sel); n_cmp++;
         if (obs !== e.exp) begin n_err++; $display("FAIL %s: got %h want %h", e.name, obs, e.exp); end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      idle_inputs();
      tick(); tick();
      rst = 1'b0;
      test_reset();
      test_write_read();
      test_collision_zero();
      test_bypass();
      test_bulk_clear();
      test_reset_mid_clear();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
